// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
package pc_gen_pkg;

    localparam int unsigned INSTR_STEP = 4;
    localparam int unsigned BTB_ENTRY_XLEN = 32;

    typedef enum logic [1:0] {
        PC_JALR   = 2'b00,
        PC_JAL    = 2'b01,
        PC_BRANCH = 2'b10,
        PC_SEQ    = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TRAP
    } pc_state_e;

    typedef struct packed {
        logic                      valid;
        logic [BTB_ENTRY_XLEN-1:0] tag;
        logic [BTB_ENTRY_XLEN-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous write/invalidate.
// Lookups see the pre-edge contents, so a same-index update is read-before-write.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BTB_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-3:0] lookup_addr,
    output logic            lookup_hit,
    output logic [XLEN-1:0] lookup_target,
    input  logic            wr_en,
    input  logic            inv_en,
    input  logic [XLEN-3:0] upd_addr,
    input  logic [XLEN-1:0] wr_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign rd_idx  = lookup_addr[IDX_W-1:0];
    assign rd_tag  = lookup_addr[XLEN-3:IDX_W];
    assign upd_idx = upd_addr[IDX_W-1:0];
    assign upd_tag = upd_addr[XLEN-3:IDX_W];

    assign lookup_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign lookup_target = target_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
        end else if (inv_en && (tag_q[upd_idx] == upd_tag)) begin
            valid_q[upd_idx] <= 1'b0;
        end
    end

    // Tag/target storage needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: owns the fetch PC, predicts next fetch, redirects on resolved mispredicts.
// Define PC_GEN_BTB_EN to instantiate the branch target buffer; otherwise prediction is pc + 4.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [1:0]      ex_pc_src,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_cond,
    input  logic [XLEN-1:0] ex_pred_pc,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign_trap
);

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_STEP);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] actual_target;
    logic            ex_active;
    logic            mispredict;
    logic            misaligned;

    assign ex_active = ex_valid && (state_q == RUN);
    assign seq_pc    = pc_q + STEP;
    assign jalr_sum  = ex_rs1 + ex_imm;

    always_comb begin
        actual_target = ex_pc + STEP;
        unique case (pc_src_e'(ex_pc_src))
            PC_JALR:   actual_target = {jalr_sum[XLEN-1:1], 1'b0};
            PC_JAL:    actual_target = ex_pc + ex_imm;
            PC_BRANCH: actual_target = ex_cond ? (ex_pc + ex_imm) : (ex_pc + STEP);
            PC_SEQ:    actual_target = ex_pc + STEP;
            default:   actual_target = ex_pc + STEP;
        endcase
    end

    assign mispredict = ex_active && (actual_target != ex_pred_pc);
    assign misaligned = mispredict && (actual_target[1:0] != 2'b00);

`ifdef PC_GEN_BTB_EN
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic            btb_wr_en;
    logic            btb_inv_en;

    assign btb_wr_en  = ex_active && ((pc_src_e'(ex_pc_src) == PC_JAL) ||
                                      ((pc_src_e'(ex_pc_src) == PC_BRANCH) && ex_cond));
    assign btb_inv_en = ex_active && (pc_src_e'(ex_pc_src) == PC_BRANCH) && !ex_cond;

    pc_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_addr   (pc_q[XLEN-1:2]),
        .lookup_hit    (btb_hit),
        .lookup_target (btb_target),
        .wr_en         (btb_wr_en),
        .inv_en        (btb_inv_en),
        .upd_addr      (ex_pc[XLEN-1:2]),
        .wr_target     (actual_target)
    );

    assign pred_pc = btb_hit ? btb_target : seq_pc;
`else
    assign pred_pc = seq_pc;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                // Redirect wins over stall; a misaligned redirect still loads pc and flushes.
                if (mispredict) begin
                    pc_d    = actual_target;
                    flush_d = 1'b1;
                    if (misaligned) begin
                        state_d = TRAP;
                    end
                end else if (!stall) begin
                    pc_d = pred_pc;
                end
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = (state_q == RUN);
    assign flush         = flush_q;
    assign misalign_trap = (state_q == TRAP);

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen; expectations adapt to whether PC_GEN_BTB_EN is defined.
module tb_pc_gen;
    import pc_gen_pkg::*;

`ifdef PC_GEN_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_pc_src = 2'b11;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_imm = '0;
    logic        ex_cond = 1'b0;
    logic [31:0] ex_pred_pc = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign_trap;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0100),
        .BTB_DEPTH    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_pc_src     (ex_pc_src),
        .ex_pc         (ex_pc),
        .ex_rs1        (ex_rs1),
        .ex_imm        (ex_imm),
        .ex_cond       (ex_cond),
        .ex_pred_pc    (ex_pred_pc),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush         (flush),
        .misalign_trap (misalign_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        vld;
        logic        fl;
        logic        trap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic push_exp(input string tag, input logic [31:0] epc, input logic v,
                            input logic f, input logic t);
        exp_t e;
        e.tag  = tag;
        e.pc   = epc;
        e.vld  = v;
        e.fl   = f;
        e.trap = t;
        exp_q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (pc === e.pc) else begin
            failures++;
            $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc, e.pc);
        end
        checks++;
        assert (pc_valid === e.vld) else begin
            failures++;
            $error("FAIL %s.pc_valid observed=%b expected=%b", e.tag, pc_valid, e.vld);
        end
        checks++;
        assert (flush === e.fl) else begin
            failures++;
            $error("FAIL %s.flush observed=%b expected=%b", e.tag, flush, e.fl);
        end
        checks++;
        assert (misalign_trap === e.trap) else begin
            failures++;
            $error("FAIL %s.trap observed=%b expected=%b", e.tag, misalign_trap, e.trap);
        end
    endtask

    // Expectation describes the outputs one edge after the currently driven inputs.
    task automatic expect_cycle(input string tag, input logic [31:0] epc, input logic v,
                                input logic f, input logic t);
        push_exp(tag, epc, v, f, t);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic drive_ex(input logic [1:0] src, input logic [31:0] p, input logic [31:0] rs1,
                            input logic [31:0] imm, input logic c, input logic [31:0] pred);
        ex_valid   = 1'b1;
        ex_pc_src  = src;
        ex_pc      = p;
        ex_rs1     = rs1;
        ex_imm     = imm;
        ex_cond    = c;
        ex_pred_pc = pred;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        push_exp("reset", 32'h100, 1'b0, 1'b0, 1'b0);
        compare_head();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Free run out of reset.
        expect_cycle("idle_to_run", 32'h100, 1'b1, 1'b0, 1'b0);
        expect_cycle("seq_104", 32'h104, 1'b1, 1'b0, 1'b0);
        expect_cycle("seq_108", 32'h108, 1'b1, 1'b0, 1'b0);

        // JAL mispredict teaches 0x200 -> 0x240.
        drive_ex(PC_JAL, 32'h200, 32'h0, 32'h40, 1'b0, 32'h204);
        expect_cycle("jal_redirect", 32'h240, 1'b1, 1'b1, 1'b0);
        idle_ex();
        expect_cycle("jal_flush_drop", 32'h244, 1'b1, 1'b0, 1'b0);

        // Sequential mispredict steers fetch back to 0x200.
        drive_ex(PC_SEQ, 32'h1fc, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_cycle("seq_to_200", 32'h200, 1'b1, 1'b1, 1'b0);
        idle_ex();
        expect_cycle("revisit_200", BTB_ON ? 32'h240 : 32'h204, 1'b1, 1'b0, 1'b0);
        expect_cycle("after_revisit", BTB_ON ? 32'h244 : 32'h208, 1'b1, 1'b0, 1'b0);

        // Not-taken branch at 0x200 invalidates the entry.
        drive_ex(PC_BRANCH, 32'h200, 32'h0, 32'h40, 1'b0, 32'h240);
        expect_cycle("br_nt_redirect", 32'h204, 1'b1, 1'b1, 1'b0);
        drive_ex(PC_SEQ, 32'h1fc, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_cycle("back_to_200", 32'h200, 1'b1, 1'b1, 1'b0);
        idle_ex();
        expect_cycle("revisit_200_inv", 32'h204, 1'b1, 1'b0, 1'b0);

        // Stall holds pc, including with a correctly predicted outcome.
        stall = 1'b1;
        expect_cycle("stall_hold", 32'h204, 1'b1, 1'b0, 1'b0);
        drive_ex(PC_SEQ, 32'h500, 32'h0, 32'h0, 1'b0, 32'h504);
        expect_cycle("stall_good_pred", 32'h204, 1'b1, 1'b0, 1'b0);

        // JALR redirect overrides stall and clears bit 0.
        drive_ex(PC_JALR, 32'h600, 32'h301, 32'h4, 1'b0, 32'h0);
        expect_cycle("jalr_over_stall", 32'h304, 1'b1, 1'b1, 1'b0);
        stall = 1'b0;
        idle_ex();
        expect_cycle("jalr_after", 32'h308, 1'b1, 1'b0, 1'b0);

        // Teach 0x104 -> 0x180 so a post-reset fetch exposes stale BTB state.
        drive_ex(PC_JAL, 32'h104, 32'h0, 32'h7c, 1'b0, 32'h108);
        expect_cycle("jal_104", 32'h180, 1'b1, 1'b1, 1'b0);
        idle_ex();
        expect_cycle("seq_184", 32'h184, 1'b1, 1'b0, 1'b0);

        // Misaligned JAL target traps.
        drive_ex(PC_JAL, 32'h400, 32'h0, 32'h2, 1'b0, 32'h404);
        expect_cycle("misalign", 32'h402, 1'b0, 1'b1, 1'b1);
        idle_ex();
        expect_cycle("trap_hold", 32'h402, 1'b0, 1'b0, 1'b1);
        drive_ex(PC_JAL, 32'h600, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_cycle("trap_ignores_ex", 32'h402, 1'b0, 1'b0, 1'b1);
        idle_ex();

        // Asynchronous reset mid-operation.
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 32'h100, 1'b0, 1'b0, 1'b0);
        compare_head();
        expect_cycle("reset_held", 32'h100, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_cycle("rerun_100", 32'h100, 1'b1, 1'b0, 1'b0);
        expect_cycle("rerun_104", 32'h104, 1'b1, 1'b0, 1'b0);
        expect_cycle("btb_cleared", 32'h108, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-side program-counter generator for the RISC-V core. It owns the architectural fetch PC register and predicts the next fetch address with an optional direct-mapped branch target buffer (BTB). It redirects fetch when the execute stage resolves a JAL, JALR, branch or sequential control outcome that differs from the prediction. It sits between the execute stage and the instruction-memory port and replaces the purely combinational next-PC mux with a parametrised, stall-aware, sequential unit.

## Interface
- XLEN, 32, datapath and PC width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned
- BTB_DEPTH, 8, number of BTB entries; power of two, at least 2
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  fetch back-pressure; hold pc when high
- ex_valid  in  1  execute stage presents a resolved control outcome this cycle
- ex_pc_src  in  2  outcome kind: 00 JALR, 01 JAL, 10 branch, 11 sequential
- ex_pc  in  XLEN  PC of the resolving instruction
- ex_rs1  in  XLEN  rs1 operand (JALR base)
- ex_imm  in  XLEN  immediate, already sign-extended to XLEN
- ex_cond  in  1  branch predicate (1 = taken); ignored unless ex_pc_src = 10
- ex_pred_pc  in  XLEN  next-PC that fetch actually used after ex_pc
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is a legal fetch request
- flush  out  1  one-cycle pulse: younger in-flight instructions are squashed
- misalign_trap  out  1  sticky: resolved target not 4-byte aligned

## Operation
- Reset values: pc = RESET_VECTOR, pc_valid = 0, flush = 0, misalign_trap = 0, state = IDLE, all BTB valid bits = 0.
- The unit has three states.
  - IDLE: entered on reset; unconditional move to RUN on the next edge. pc_valid becomes 1 in RUN.
  - RUN: normal fetch. Moves to TRAP on a misaligned resolved target.
  - TRAP: pc_valid = 0 and misalign_trap = 1. The unit holds here until rst_n is asserted.
- Actual target computation, modulo 2^XLEN:
  - JALR: (ex_rs1 + ex_imm) with bit 0 cleared.
  - JAL: ex_pc + ex_imm.
  - Branch: ex_pc + ex_imm if ex_cond, else ex_pc + 4.
  - Sequential: ex_pc + 4.
- Mispredict = ex_valid && (actual target != ex_pred_pc).
- Next pc while in RUN, highest priority first:
  - Mispredict: pc <= actual target.
  - stall: pc holds.
  - Otherwise: pc <= BTB prediction for the current pc.
- Misaligned: mispredict with actual target[1:0] != 0. The unit loads pc <= target, enters TRAP and sets misalign_trap. flush is still pulsed.
- BTB lookup:
  - index = pc[log2(BTB_DEPTH)+1:2]; tag = remaining upper bits of pc.
  - A hit (valid && tag match) predicts the stored target; a miss predicts pc + 4.
- BTB update, only when ex_valid:
  - JAL, or taken branch: write {valid, tag(ex_pc), actual target}.
  - Not-taken branch whose tag matches the entry: clear valid.
  - JALR and sequential outcomes: no update.
- Same-cycle read and write to one index: the lookup returns the old contents (read-before-write).

## Timing
- Prediction latency: 1 cycle; pc advances every unstalled edge.
- Redirect latency: 1 cycle.
  - Mispredict at edge N: pc = corrected target and flush = 1 during cycle N+1.
  - flush deasserts at N+2 unless another mispredict arrives.
- A redirect overrides stall in the same cycle. A correctly predicted ex_valid while stalled leaves pc held.
- Reset mid-operation:
  - All outputs and the BTB valid bits clear immediately (asynchronous).
  - The first valid fetch is RESET_VECTOR, one cycle after rst_n deasserts.
- Any ex_valid while in IDLE or TRAP is ignored, including BTB updates.

## Configuration
- PC_GEN_BTB_EN defined: the BTB is instantiated; prediction and update behave as specified above.
- PC_GEN_BTB_EN undefined:
  - No BTB storage; the prediction is always pc + 4 and BTB_DEPTH is ignored.
  - Redirect, flush, stall and trap behaviour are unchanged.

## Structure
- Package pc_gen_pkg holds:
  - pc_src_e enum: PC_JALR = 2'b00, PC_JAL = 2'b01, PC_BRANCH = 2'b10, PC_SEQ = 2'b11.
  - pc_state_e enum: IDLE, RUN, TRAP.
  - btb_entry_t struct: valid, tag, target.
  - Constant for the instruction step of 4.
- The BTB is a separate sub-module, pc_btb, parametrised by XLEN and BTB_DEPTH. It has one combinational lookup port and one synchronous write/invalidate port, and its valid bits are cleared asynchronously on rst_n.

## Test plan
- Reset and free-run: release rst_n with RESET_VECTOR = 0x100 and no ex_valid -> pc_valid rises one cycle later; pc goes 0x100, 0x104, 0x108 on consecutive edges.
- JAL mispredict:
  - Stimulus: ex_valid, pc_src = 01, ex_pc = 0x200, ex_imm = 0x40, ex_pred_pc = 0x204.
  - Next cycle: pc = 0x240 and flush = 1 for exactly one cycle.
  - When fetch returns to 0x200: pc = 0x240 the following cycle with no flush (BTB hit).
- Branch not taken invalidates: after the BTB learns 0x200 -> 0x240, resolve a branch at 0x200 with ex_cond = 0 and ex_pred_pc = 0x240 -> pc = 0x204 and flush pulses; the next visit to 0x200 predicts 0x204.
- JALR alignment and priority: stall = 1 with JALR ex_rs1 = 0x301, ex_imm = 0x4, ex_pred_pc = 0x0 -> pc = 0x304 despite stall, and flush = 1.
- Misaligned trap: JAL with ex_pc = 0x400, ex_imm = 0x2 -> pc = 0x402, misalign_trap = 1 and pc_valid = 0; the unit stays there until rst_n asserts, then returns to RESET_VECTOR.
- Macro off: build without PC_GEN_BTB_EN and repeat the JAL scenario -> every revisit to 0x200 predicts 0x204 and mispredicts again.
